// File: rtl/t05_htree_arbiter_pkg.sv
// Shared types for the htree RAM arbiter: state encoding, default widths and
// the htree element layout (max_index | child1 | child0 | sum, MSB first).
package t05_pkg;

    localparam int T05_ADDR_W   = 7;
    localparam int T05_ELEM_W   = 71;
    localparam int T05_MAX_WAIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Child fields are 9 bits: a leaf flag on top of an 8-bit node/symbol value.
    localparam int MAXIDX_W   = 7;
    localparam int CHILD_W    = 9;
    localparam int SUM_W      = 46;
    localparam int SUM_LSB    = 0;
    localparam int CHILD0_LSB = SUM_LSB + SUM_W;
    localparam int CHILD1_LSB = CHILD0_LSB + CHILD_W;
    localparam int MAXIDX_LSB = CHILD1_LSB + CHILD_W;

    function automatic logic [T05_ELEM_W-1:0] pack_elem(
        input logic [MAXIDX_W-1:0] max_index,
        input logic [CHILD_W-1:0]  child1,
        input logic [CHILD_W-1:0]  child0,
        input logic [SUM_W-1:0]    sum
    );
        return {max_index, child1, child0, sum};
    endfunction

endpackage

// File: rtl/t05_htree_arbiter_if.sv
// Single-port htree RAM bus. The arbiter drives the master side, the RAM the slave side.
interface t05_htree_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int ELEM_W = 71
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [ELEM_W-1:0] mem_wdata;
    logic [ELEM_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/t05_rr_grant2.sv
// Two-way round-robin grant with a 1-bit last-grant pointer (0 = writer, 1 = reader).
module t05_rr_grant2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt,
    output logic       gnt_valid
);
    logic last_q, last_d;

    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            gnt = ~last_q;
        end else begin
            gnt = req[1];
        end
        last_d = (accept && gnt_valid) ? gnt : last_q;
    end

    // Pointer starts at "reader was last" so the first contention goes to the writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/t05_htree_arbiter.sv
// Arbitrates the tree builder (writer) and codebook walker (reader) onto one htree RAM.
// Optional macro HTREE_ARB_TIMEOUT_EN adds a MAX_WAIT watchdog on the RAM handshake.
module t05_htree_arbiter
    import t05_pkg::*;
#(
    parameter int ADDR_W   = T05_ADDR_W,
    parameter int ELEM_W   = T05_ELEM_W,
    parameter int MAX_WAIT = T05_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_index,
    input  logic [ELEM_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [ELEM_W-1:0] rd_data,
    output logic              rd_valid,
    t05_htree_arbiter_if.master mem,
    output logic              busy,
    output logic              owner,
    output logic              err,
    output logic [1:0]        dbg_state
);
    // Handshake: a requester raises req with index/data and holds them until it sees
    // its one-cycle wr_ack/rd_valid; the RAM answers an mem_en pulse with one mem_ready
    // cycle, any number of cycles later. Only one transaction is ever outstanding.
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ELEM_W-1:0] wdata_q, wdata_d;
    logic [ELEM_W-1:0] rdata_q, rdata_d;
    logic              owner_q, owner_d;
    logic              gnt, gnt_valid;

`ifdef HTREE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             err_q, err_d;
`endif

    t05_rr_grant2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       ({rd_req, wr_req}),
        .accept    (state_q == S_IDLE),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        owner_d = owner_q;
`ifdef HTREE_ARB_TIMEOUT_EN
        err_d   = err_q;
        wcnt_d  = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt;
                    we_d    = ~gnt;
                    addr_d  = gnt ? rd_index : wr_index;
                    wdata_d = gnt ? '0 : wr_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mem.mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = S_RESP;
                end
`ifdef HTREE_ARB_TIMEOUT_EN
                // A timed-out read still completes, but with a zero element.
                else if (wcnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            owner_q <= 1'b0;
`ifdef HTREE_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            owner_q <= owner_d;
`ifdef HTREE_ARB_TIMEOUT_EN
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    assign mem.mem_en    = (state_q == S_ISSUE);
    assign mem.mem_we    = (state_q == S_ISSUE) && we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign wr_ack        = (state_q == S_RESP) && we_q;
    assign rd_valid      = (state_q == S_RESP) && !we_q;
    assign rd_data       = rdata_q;
    assign busy          = (state_q != S_IDLE);
    assign owner         = owner_q;
    assign dbg_state     = state_q;

`ifdef HTREE_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT > 0);
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_t05_htree_arbiter.sv
// Directed bench for t05_htree_arbiter: RAM model with programmable wait states,
// expected-response queue checked by an independent monitor.
module tb_t05_htree_arbiter;
    import t05_pkg::*;

    localparam int AW = 7;
    localparam int EW = 71;
    localparam int W  = EW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_index = '0;
    logic [EW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_index = '0;
    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic          busy, owner, err;
    logic [1:0]    dbg_state;

    t05_htree_arbiter_if #(.ADDR_W(AW), .ELEM_W(EW)) mif ();

    t05_htree_arbiter #(.ADDR_W(AW), .ELEM_W(EW), .MAX_WAIT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .mem       (mif),
        .busy      (busy),
        .owner     (owner),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_e;
    logic [EW-1:0] ram [128];
    logic [EW-1:0] ref_mem [128];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int last_resp_cyc = 0;
    int ready_cyc = 0;
    int ready_cnt = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    int mem_delay = 0;
    bit mem_never = 1'b0;

    function automatic logic [EW-1:0] fill_val(input int i);
        if (i == 8) return pack_elem(7'd8, {1'b1, 8'd6}, {1'b1, 8'd7}, 46'd52);
        return EW'({32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'hA5A5_0F0F, 32'(i)});
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mif.mem_en) en_cnt++;
        if (mif.mem_we) we_cnt++;
    end

    // RAM model: samples the request mid-cycle, answers mem_delay cycles after the minimum.
    initial begin
        logic          en_s, we_s, pend, pend_we;
        logic [AW-1:0] a_s, pend_a;
        logic [EW-1:0] d_s;
        int            pend_cnt;
        pend = 1'b0; pend_we = 1'b0; pend_a = '0; pend_cnt = 0;
        for (int i = 0; i < 128; i++) ram[i] = fill_val(i);
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            en_s = mif.mem_en; we_s = mif.mem_we; a_s = mif.mem_addr; d_s = mif.mem_wdata;
            @(posedge clk);
            #1;
            mif.mem_ready = 1'b0;
            if (en_s) begin
                pend = 1'b1; pend_we = we_s; pend_a = a_s; pend_cnt = mem_delay;
                if (we_s) ram[a_s] = d_s;
            end
            if (mem_never) pend = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = pend_we ? '0 : ram[pend_a];
                    pend = 1'b0;
                    ready_cyc = cyc;
                    ready_cnt++;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    // Monitor: every response must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (wr_ack || rd_valid)) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            check("ack_exclusive", W'(wr_ack & rd_valid), W'(0));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got wr_ack=%0b rd_valid=%0b expected no response", wr_ack, rd_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_kind", W'(rd_valid), W'(mon_e[W-1]));
                check("resp_owner", W'(owner), W'(mon_e[W-1]));
                if (mon_e[W-1]) check("rd_data", W'(rd_data), W'(mon_e[EW-1:0]));
            end
        end
    end

    task automatic exp_wr(input logic [AW-1:0] idx, input logic [EW-1:0] d);
        ref_mem[idx] = d;
        exp_q.push_back({1'b0, d});
    endtask

    task automatic exp_rd(input logic [AW-1:0] idx);
        exp_q.push_back({1'b1, ref_mem[idx]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},      W'(busy),           W'(0));
        check({pfx, "_owner"},     W'(owner),          W'(0));
        check({pfx, "_err"},       W'(err),            W'(0));
        check({pfx, "_wr_ack"},    W'(wr_ack),         W'(0));
        check({pfx, "_rd_valid"},  W'(rd_valid),       W'(0));
        check({pfx, "_mem_en"},    W'(mif.mem_en),     W'(0));
        check({pfx, "_mem_we"},    W'(mif.mem_we),     W'(0));
        check({pfx, "_mem_addr"},  W'(mif.mem_addr),   W'(0));
        check({pfx, "_mem_wdata"}, W'(mif.mem_wdata),  W'(0));
        check({pfx, "_rd_data"},   W'(rd_data),        W'(0));
        check({pfx, "_state"},     W'(dbg_state),      W'(ST_IDLE));
    endtask

    // Called at a negedge; holds the request until the response, then drops it.
    task automatic run_txn(input bit is_rd, input logic [AW-1:0] idx, input logic [EW-1:0] data,
                           output int ncyc, output bit bz_ok);
        ncyc = 0;
        bz_ok = 1'b1;
        if (is_rd) begin
            rd_req = 1'b1; rd_index = idx;
        end else begin
            wr_req = 1'b1; wr_index = idx; wr_data = data;
        end
        do begin
            @(negedge clk);
            ncyc++;
            if (!busy) bz_ok = 1'b0;
        end while (!(wr_ack || rd_valid) && ncyc < 200);
        rd_req = 1'b0;
        wr_req = 1'b0;
        if (!(wr_ack || rd_valid)) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: got no response after %0d cycles expected a response", ncyc);
        end
    endtask

    initial begin
        int            ncyc, e0, w0, r0, rc0, got, k;
        bit            bz, bad;
        logic [EW-1:0] d;
        for (int i = 0; i < 128; i++) ref_mem[i] = fill_val(i);

        do_reset();
        check_all_zero("reset");

        // Single zero-wait read of index 8
        exp_rd(7'd8);
        e0 = en_cnt;
        run_txn(1'b1, 7'd8, '0, ncyc, bz);
        check("rd_latency", W'(ncyc), W'(3));
        check("rd_busy", W'(bz), W'(1));
        check("rd_en_count", W'(en_cnt - e0), W'(1));
        @(negedge clk);
        check("rd_idle_after", W'(busy), W'(0));

        // Continuous contention from reset: writer, reader, writer
        do_reset();
        d = pack_elem(7'd5, {1'b0, 8'd1}, {1'b0, 8'd2}, 46'd1234);
        exp_wr(7'd5, d);
        exp_rd(7'd9);
        exp_wr(7'd5, d);
        r0 = resp_cnt;
        wr_req = 1'b1; wr_index = 7'd5; wr_data = d;
        rd_req = 1'b1; rd_index = 7'd9;
        got = 0;
        k = 0;
        while (got < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (wr_ack || rd_valid) got++;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("contention_resp_count", W'(resp_cnt - r0), W'(3));
        check("contention_idle", W'(busy), W'(0));

        // Write index 3 then read it back
        d = pack_elem(7'd8, {1'b1, 8'd0}, {1'b0, 8'd65}, 46'd10);
        exp_wr(7'd3, d);
        w0 = we_cnt;
        run_txn(1'b0, 7'd3, d, ncyc, bz);
        check("wr_latency", W'(ncyc), W'(3));
        check("wr_we_count", W'(we_cnt - w0), W'(1));
        @(negedge clk);
        exp_rd(7'd3);
        w0 = we_cnt;
        run_txn(1'b1, 7'd3, '0, ncyc, bz);
        check("rdback_we_count", W'(we_cnt - w0), W'(0));
        @(negedge clk);

        // Five wait states
        mem_delay = 5;
        exp_rd(7'd8);
        e0 = en_cnt;
        run_txn(1'b1, 7'd8, '0, ncyc, bz);
        @(negedge clk);
        check("wait_latency", W'(ncyc), W'(8));
        check("wait_busy", W'(bz), W'(1));
        check("wait_en_count", W'(en_cnt - e0), W'(1));
        check("wait_valid_after_ready", W'(last_resp_cyc - ready_cyc), W'(1));
        mem_delay = 0;

        // Reset while waiting on the RAM; the late mem_ready must be ignored
        mem_delay = 6;
        rc0 = ready_cnt;
        r0 = resp_cnt;
        rd_req = 1'b1;
        rd_index = 7'd8;
        repeat (3) @(negedge clk);
        check("pre_rst_state", W'(dbg_state), W'(ST_WAIT));
        rst = 1'b1;
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_wait");
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rd_valid || wr_ack || busy) bad = 1'b1;
        end
        check("late_ready_ignored", W'(bad), W'(0));
        check("late_ready_delivered", W'(ready_cnt - rc0), W'(1));
        check("no_resp_after_rst", W'(resp_cnt - r0), W'(0));
        mem_delay = 0;

`ifdef HTREE_ARB_TIMEOUT_EN
        // RAM never answers: 15 WAIT cycles, zero data, sticky err
        mem_never = 1'b1;
        exp_q.push_back({1'b1, EW'(0)});
        run_txn(1'b1, 7'd8, '0, ncyc, bz);
        check("timeout_latency", W'(ncyc), W'(17));
        check("timeout_err", W'(err), W'(1));
        repeat (5) @(negedge clk);
        check("timeout_err_sticky", W'(err), W'(1));
        check("timeout_idle", W'(busy), W'(0));
        mem_never = 1'b0;
        do_reset();
        check("timeout_err_cleared", W'(err), W'(0));
`else
        // Without the watchdog a long RAM stall simply waits
        mem_delay = 20;
        exp_rd(7'd8);
        run_txn(1'b1, 7'd8, '0, ncyc, bz);
        check("long_wait_latency", W'(ncyc), W'(23));
        check("long_wait_err", W'(err), W'(0));
        mem_delay = 0;
`endif

        repeat (2) @(negedge clk);
        check("exp_q_empty", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/t05_htree_arbiter.md
T05_HTREE_ARBITER -- requirements
Module: t05_htree_arbiter

Interface
REQ-001 Params: ADDR_W, default 7, htree index width; ELEM_W, default 71, htree element width; MAX_WAIT, default 15, memory wait timeout in cycles.
REQ-002 Ports SHALL be: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-003 wr_req in 1, wr_index in ADDR_W, wr_data in ELEM_W: tree-builder write request (requester 0); wr_ack out 1: write done.
REQ-004 rd_req in 1, rd_index in ADDR_W: codebook-walker read request (requester 1); rd_data out ELEM_W, rd_valid out 1: read result.
REQ-005 mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out ELEM_W, mem_rdata in ELEM_W, mem_ready in 1: single-port htree RAM.
REQ-006 busy out 1 (state != IDLE); owner out 1 (0 = writer, 1 = reader; last grant); err out 1 (sticky timeout flag).

Function
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at any time.
REQ-008 IDLE: on an edge with any req high, latch index/data/we of the winner, set owner, go ISSUE; otherwise stay.
REQ-009 Arbitration SHALL be round-robin: when both requests are high, grant the requester not granted last; the first contention after reset grants the writer.
REQ-010 ISSUE: mem_en=1 for exactly one cycle with latched mem_addr/mem_we/mem_wdata (mem_wdata=0 for reads); next state WAIT.
REQ-011 WAIT: mem_en=0, address/data held; on an edge with mem_ready=1, capture mem_rdata for reads and go RESP.
REQ-012 RESP: exactly one cycle with wr_ack=1 (write) or rd_valid=1 (read); rd_data holds the captured value until the next read completes; next state IDLE.
REQ-013 Minimum latency: req high before edge N, mem_ready high at edge N+2 -> ack/valid high in cycle N+2..N+3; IDLE at N+3.
REQ-014 Requesters SHALL hold req, index and data until ack/valid; a req still high in IDLE after RESP is a new transaction.
REQ-015 Req dropped mid-transaction: the transaction still completes and ack/valid still pulses.
REQ-016 The index is passed through unmodified; no bounds check against max_index.
REQ-017 wr_ack and rd_valid SHALL never be high in the same cycle.

Reset
REQ-018 rst SHALL force state IDLE; wr_ack, rd_valid, mem_en, mem_we, busy, err, owner = 0; mem_addr, mem_wdata, rd_data = 0; round-robin pointer -> writer-first.
REQ-019 rst mid-transaction SHALL abandon it without ack/valid; mem_ready arriving afterwards is ignored.

Configuration
REQ-020 Macro HTREE_ARB_TIMEOUT_EN defined: a wait counter runs in WAIT; after MAX_WAIT cycles without mem_ready, set err (sticky until rst), pulse ack/valid with rd_data=0, return IDLE via RESP.
REQ-021 Macro not defined: no counter; WAIT persists until mem_ready; err is tied to 0.

Structure
REQ-022 The shared package t05_pkg SHALL hold the arbiter state enum, ADDR_W/ELEM_W defaults, and the htree element field offsets (7-bit max_index, two 9-bit child fields, 46-bit sum).
REQ-023 The round-robin grant logic SHALL be the sub-module t05_rr_grant2 (2 requests, 1-bit last-grant pointer, grant + valid outputs).

Verification
REQ-024 Single read: rd_req, rd_index=8, RAM holds {8,{1,6},{1,7},52} with zero wait -> rd_valid one cycle at N+2, rd_data equals that element, wr_ack=0.
REQ-025 Contention: wr_req and rd_req high together, held continuously, from reset -> grants in order writer, reader, writer; owner toggles; each ack/valid pulses once per transaction.
REQ-026 Write then read-back: write index 3 = {8,{1,0},{0,65},10}, then read index 3 -> mem_we=1 only during the write ISSUE cycle; rd_data matches the written element.
REQ-027 Wait states: mem_ready delayed 5 cycles -> mem_en high for one cycle only, busy high throughout, rd_valid at the edge after mem_ready.
REQ-028 Reset in WAIT: assert rst -> next cycle all outputs 0, no rd_valid; a late mem_ready is ignored.
REQ-029 With HTREE_ARB_TIMEOUT_EN defined and mem_ready never high -> after 15 WAIT cycles err=1, rd_valid pulses with rd_data=0, FSM returns to IDLE, err stays 1 until rst.
